// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide requester controller.
package multdiv_pkg;

  localparam int unsigned TAG_W_DEF   = 5;
  localparam int unsigned TIMEOUT_DEF = 40;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating wait-cycle counter; term flags a count of TIMEOUT-1.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TERM)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == TERM);

endmodule

// File: rtl/multdiv_issue.sv
// Issues one MULT/DIV to the iterative unit, waits for ready (bounded by a
// timeout) and returns the result as a one-cycle writeback pulse.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  input  logic             req_is_div,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             stall,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_exception,
  output logic             wb_timeout
);

  md_state_e        state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             is_div_q, is_div_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             wb_exc_q, wb_exc_d;
  logic             wb_to_q, wb_to_d;
  logic             cnt_clear, cnt_enable, cnt_term;

  md_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .term  (cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    is_div_d   = is_div_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    wb_exc_d   = wb_exc_q;
    wb_to_d    = wb_to_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          a_d      = req_a;
          b_d      = req_b;
          tag_d    = req_tag;
          is_div_d = req_is_div;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clear = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_enable = 1'b1;
        // Ready takes priority over a timeout landing in the same cycle.
        if (md_resultRDY) begin
          wb_data_d = md_result;
          wb_exc_d  = md_exception;
          wb_to_d   = 1'b0;
          wb_tag_d  = tag_q;
          state_d   = DONE;
        end else if (cnt_term) begin
          wb_data_d = '0;
          wb_exc_d  = 1'b1;
          wb_to_d   = 1'b1;
          wb_tag_d  = tag_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d   = IDLE;
      wb_data_d = wb_data_q;
      wb_tag_d  = wb_tag_q;
      wb_exc_d  = wb_exc_q;
      wb_to_d   = wb_to_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      is_div_q  <= OP_MULT;
      wb_data_q <= '0;
      wb_tag_q  <= '0;
      wb_exc_q  <= 1'b0;
      wb_to_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      is_div_q  <= is_div_d;
      wb_data_q <= wb_data_d;
      wb_tag_q  <= wb_tag_d;
      wb_exc_q  <= wb_exc_d;
      wb_to_q   <= wb_to_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign stall        = (state_q != IDLE);
  assign md_operandA  = a_q;
  assign md_operandB  = b_q;
  assign md_ctrl_MULT = (state_q == ISSUE) && (is_div_q == OP_MULT);
  assign md_ctrl_DIV  = (state_q == ISSUE) && (is_div_q == OP_DIV);

  // DONE lasts one cycle, so a flush arriving in it must gate the pulse directly.
  assign wb_valid     = (state_q == DONE) && !flush;
  assign wb_data      = wb_data_q;
  assign wb_tag       = wb_tag_q;
  assign wb_exception = wb_exc_q;
  assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the bench plays the iterative unit.
module tb_multdiv_issue;

  localparam int unsigned TW = 5;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          req_valid;
  logic          req_is_div;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          stall;
  logic [31:0]   md_operandA;
  logic [31:0]   md_operandB;
  logic          md_ctrl_MULT;
  logic          md_ctrl_DIV;
  logic [31:0]   md_result;
  logic          md_exception;
  logic          md_resultRDY;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [TW-1:0] wb_tag;
  logic          wb_exception;
  logic          wb_timeout;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  multdiv_issue #(
    .TIMEOUT(40),
    .TAG_W  (TW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_is_div  (req_is_div),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .stall       (stall),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV (md_ctrl_DIV),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_tag      (wb_tag),
    .wb_exception(wb_exception),
    .wb_timeout  (wb_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full operation: accept in cycle 0, ISSUE in cycle 1, rdy_at==0 means the
  // unit never answers and the 40-cycle timeout must complete the op.
  task automatic do_op(input string nm, input logic is_div, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] tag,
                       input int unsigned rdy_at, input logic [31:0] res,
                       input logic exc, input logic stale);
    int unsigned n_wait;
    logic [31:0] ed;
    logic        ee, et;
    n_wait = (rdy_at == 0) ? 40 : rdy_at;
    ed = (rdy_at == 0) ? 32'd0 : res;
    ee = (rdy_at == 0) ? 1'b1 : exc;
    et = (rdy_at == 0);

    n_cmp++;
    if ({req_ready, stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s idle_before: got ready/stall=%b want 10", nm, {req_ready, stall});
    end
    req_valid = 1'b1; req_is_div = is_div; req_a = a; req_b = b; req_tag = tag;
    tick();
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_tag = ~tag; req_is_div = ~is_div;

    n_cmp++;
    if ({stall, req_ready, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== {1'b1, 1'b0, ~is_div, is_div, 1'b0}) begin
      n_fail++;
      $display("FAIL %s issue: got stall/rdy/mul/div/wb=%b want %b", nm,
               {stall, req_ready, md_ctrl_MULT, md_ctrl_DIV, wb_valid},
               {1'b1, 1'b0, ~is_div, is_div, 1'b0});
    end
    n_cmp++;
    if ({md_operandA, md_operandB} !== {a, b}) begin
      n_fail++;
      $display("FAIL %s operands: got %h/%h want %h/%h", nm, md_operandA, md_operandB, a, b);
    end
    if (stale) begin
      md_resultRDY = 1'b1; md_result = 32'hBAD0_BAD0; md_exception = 1'b1;
    end

    for (int unsigned j = 1; j <= n_wait; j++) begin
      tick();
      md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
      n_cmp++;
      if ({stall, req_ready, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== 5'b10000) begin
        n_fail++;
        $display("FAIL %s wait%0d: got stall/rdy/mul/div/wb=%b want 10000", nm, j,
                 {stall, req_ready, md_ctrl_MULT, md_ctrl_DIV, wb_valid});
      end
      if (j == rdy_at) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end
    end

    tick();
    md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
    n_cmp++;
    if ({stall, req_ready, wb_valid, md_ctrl_MULT, md_ctrl_DIV} !== 5'b10100) begin
      n_fail++;
      $display("FAIL %s done: got stall/rdy/wb/mul/div=%b want 10100", nm,
               {stall, req_ready, wb_valid, md_ctrl_MULT, md_ctrl_DIV});
    end
    n_cmp++;
    if ({wb_data, wb_tag, wb_exception, wb_timeout} !== {ed, tag, ee, et}) begin
      n_fail++;
      $display("FAIL %s wb_fields: got data=%h tag=%0d exc=%b to=%b want data=%h tag=%0d exc=%b to=%b",
               nm, wb_data, wb_tag, wb_exception, wb_timeout, ed, tag, ee, et);
    end

    tick();
    n_cmp++;
    if ({stall, req_ready, wb_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s idle_after: got stall/rdy/wb=%b want 010", nm, {stall, req_ready, wb_valid});
    end
    n_cmp++;
    if ({md_operandA, md_operandB} !== {a, b}) begin
      n_fail++;
      $display("FAIL %s operands_hold: got %h/%h want %h/%h", nm, md_operandA, md_operandB, a, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_div = 1'b0;
    req_a = '0; req_b = '0; req_tag = '0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({req_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_timeout} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {req_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_timeout});
    end
    n_cmp++;
    if ({md_operandA, md_operandB, wb_data, wb_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%h b=%h data=%h tag=%0d want all 0",
               md_operandA, md_operandB, wb_data, wb_tag);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    do_op("mult_6x7", 1'b0, 32'd6, 32'd7, 5'd3, 17, 32'd42, 1'b0, 1'b0);
  endtask

  task automatic test_div_exception();
    do_op("div_by_zero", 1'b1, 32'd100, 32'd0, 5'd8, 33, 32'hFFFF_FFFF, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    do_op("timeout", 1'b0, 32'd3, 32'd5, 5'd12, 0, 32'd15, 1'b0, 1'b0);
  endtask

  task automatic test_rdy_at_timeout();
    do_op("rdy_wins", 1'b1, 32'd50, 32'd5, 5'd1, 40, 32'd10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("min_latency", 1'b0, 32'd2, 32'd3, 5'd31, 1, 32'd6, 1'b0, 1'b0);
    do_op("b2b_div", 1'b1, 32'd81, 32'd9, 5'd0, 2, 32'd9, 1'b0, 1'b0);
  endtask

  task automatic test_stale_rdy();
    do_op("stale_rdy", 1'b0, 32'd9, 32'd9, 5'd7, 5, 32'd81, 1'b0, 1'b1);
  endtask

  task automatic test_flush_wait();
    req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd11; req_b = 32'd13; req_tag = 5'd4;
    tick();
    req_valid = 1'b0;
    for (int unsigned j = 1; j <= 5; j++) tick();
    flush = 1'b1;
    tick();
    n_cmp++;
    if ({stall, req_ready, wb_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_wait_idle: got stall/rdy/wb=%b want 010", {stall, req_ready, wb_valid});
    end
    n_cmp++;
    if ({md_operandA, md_operandB} !== {32'd11, 32'd13}) begin
      n_fail++;
      $display("FAIL flush_wait_operands: got %h/%h want %h/%h", md_operandA, md_operandB, 32'd11, 32'd13);
    end
    flush = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_wait_no_wb: got wb_valid=%b want 0", wb_valid);
      end
    end
    do_op("after_flush", 1'b0, 32'd5, 32'd9, 5'd9, 3, 32'd45, 1'b0, 1'b0);
  endtask

  task automatic test_flush_done();
    req_valid = 1'b1; req_is_div = 1'b1; req_a = 32'd7; req_b = 32'd2; req_tag = 5'd6;
    tick();
    req_valid = 1'b0;
    tick();
    md_resultRDY = 1'b1; md_result = 32'd3;
    tick();
    md_resultRDY = 1'b0; md_result = '0;
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({stall, wb_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_done: got stall/wb=%b want 10", {stall, wb_valid});
    end
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({stall, req_ready, wb_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_done_idle: got stall/rdy/wb=%b want 010", {stall, req_ready, wb_valid});
    end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1; req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd99; req_b = 32'd98;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if ({req_ready, stall, md_ctrl_MULT, md_ctrl_DIV} !== 4'b1000) begin
      n_fail++;
      $display("FAIL flush_idle: got rdy/stall/mul/div=%b want 1000",
               {req_ready, stall, md_ctrl_MULT, md_ctrl_DIV});
    end
    n_cmp++;
    if ({md_operandA, md_operandB} !== {32'd7, 32'd2}) begin
      n_fail++;
      $display("FAIL flush_idle_operands: got %h/%h want %h/%h", md_operandA, md_operandB, 32'd7, 32'd2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd21; req_b = 32'd2; req_tag = 5'd17;
    tick();
    req_valid = 1'b0;
    for (int unsigned j = 1; j <= 3; j++) tick();
    reset = 1'b1; req_valid = 1'b1; req_is_div = 1'b1; req_a = 32'd18; req_b = 32'd9; req_tag = 5'd2;
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({req_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_timeout} !== 7'b1000000) begin
        n_fail++;
        $display("FAIL reset_mid_ctrl%0d: got %b want 1000000", k,
                 {req_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_timeout});
      end
      n_cmp++;
      if ({md_operandA, md_operandB, wb_data, wb_tag} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_data%0d: got a=%h b=%h data=%h tag=%0d want all 0", k,
                 md_operandA, md_operandB, wb_data, wb_tag);
      end
    end
    reset = 1'b0;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if ({stall, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB} !== {3'b101, 32'd18, 32'd9}) begin
      n_fail++;
      $display("FAIL reset_mid_reissue: got stall/mul/div=%b a=%h b=%h want 101 a=%h b=%h",
               {stall, md_ctrl_MULT, md_ctrl_DIV}, md_operandA, md_operandB, 32'd18, 32'd9);
    end
    tick();
    md_resultRDY = 1'b1; md_result = 32'd2;
    tick();
    md_resultRDY = 1'b0; md_result = '0;
    n_cmp++;
    if ({wb_valid, wb_data, wb_tag, wb_exception, wb_timeout} !== {1'b1, 32'd2, 5'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_wb: got wb=%b data=%h tag=%0d exc=%b to=%b want 1 00000002 2 0 0",
               wb_valid, wb_data, wb_tag, wb_exception, wb_timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_exception();
    test_timeout();
    test_rdy_at_timeout();
    test_back_to_back();
    test_stale_rdy();
    test_flush_wait();
    test_flush_done();
    test_flush_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
